neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of each input sample and each weight (two's complement).
REQ-002 SHALL have parameter WEIGHT_INT_WIDTH, default 4, weight integer bits; weight format is 1 sign, WEIGHT_INT_WIDTH integer, rest fraction.
REQ-003 SHALL have parameter NUM_INPUTS, default 4, number of inputs summed per output; range 2..65535.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1, synchronous abort of the current pass.
REQ-007 SHALL have port in_valid, input, 1, in_data valid this cycle; no backpressure.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, signed input sample.
REQ-009 SHALL have port w_addr, output, clog2(NUM_INPUTS), weight ROM address.
REQ-010 SHALL have port w_data, input, DATA_WIDTH, signed weight; ROM read latency exactly 1 cycle.
REQ-011 SHALL have port bias, input, 2*DATA_WIDTH, signed bias in the product format; sampled on the final accumulate edge.
REQ-012 SHALL have port out_valid, output, 1, one-cycle pulse marking out_sum valid.
REQ-013 SHALL have port out_sum, output, 2*DATA_WIDTH, signed neuron sum for the downstream activation stage; format: sign, weight integer, input integer, weight fraction, input fraction.

Function
REQ-014 SHALL drive w_addr combinationally from the input index counter idx (0..NUM_INPUTS-1), so the weight for the sample accepted in cycle T is on w_data in cycle T+1.
REQ-015 Stage 1 (edge ending T) SHALL register in_data and valid v1 <= in_valid.
REQ-016 Stage 2 (edge ending T+1) SHALL register prod <= full-precision signed product of stage-1 data and w_data, 2*DATA_WIDTH bits, plus v2 <= v1 and last2 <= (sample was index NUM_INPUTS-1).
REQ-017 Stage 3 (edge ending T+2), when v2: acc <= sat(acc + prod); when v2 and last2 instead out_sum <= sat(sat(acc + prod) + bias), out_valid <= 1, acc <= 0.
REQ-018 sat() SHALL clamp to [-2^(2*DATA_WIDTH-1), 2^(2*DATA_WIDTH-1)-1]; no wrap-around ever.
REQ-019 Latency: out_valid SHALL assert in cycle T+3, T = cycle of the final in_valid of the pass; high exactly one cycle.
REQ-020 out_sum SHALL hold its value until the next out_valid.
REQ-021 idx SHALL advance on each accepted in_valid and wrap from NUM_INPUTS-1 to 0; in_valid gaps of any length SHALL be allowed mid-pass.
REQ-022 FSM: IDLE (idx=0, acc=0, pipeline empty) -> ACCUM on first in_valid; ACCUM -> IDLE when the final product accumulates and no further in_valid is in flight; otherwise stays ACCUM.
REQ-023 Back-to-back passes SHALL be supported: the first product of pass N+1 arriving on the cycle after the final one of pass N SHALL see acc=0, no bubble.
REQ-024 clear SHALL on that edge zero idx, acc, v1, v2 and out_valid and force IDLE; an in_valid in the same cycle as clear SHALL be discarded.
REQ-025 A pass with fewer than NUM_INPUTS samples SHALL never produce out_valid unless completed.

Reset
REQ-026 rst_n low SHALL immediately set out_valid=0, out_sum=0, acc=0, idx=0 (w_addr=0), v1=v2=0, state IDLE, regardless of clock.
REQ-027 Reset asserted mid-pass SHALL discard all partial results; first pass after release starts at index 0.

Verification
REQ-028 Nominal: NUM_INPUTS=4, in_data=0x0100, w_data=0x0800 all, bias=0, contiguous in_valid -> out_valid 3 cycles after the 4th sample, out_sum=0x00200000.
REQ-029 Positive saturation: in_data=0x7FFF, w_data=0x7FFF x4, bias=0 -> out_sum=0x7FFFFFFF.
REQ-030 Negative saturation: in_data=0x8000, w_data=0x7FFF x4, bias=0x00001000 -> out_sum=0x80000000 plus bias after clamp = 0x80001000.
REQ-031 Bias only: in_data=0 x4, bias=0xFFFF0000 -> out_sum=0xFFFF0000.
REQ-032 Back-to-back plus gaps: two passes of 8 contiguous samples, then one pass with 2-cycle gaps -> three out_valid pulses, each sum independent, w_addr sequence 0,1,2,3 repeating.
REQ-033 Abort: clear (or rst_n low) after 2 samples, then 4 fresh samples -> exactly one out_valid, sum of the 4 fresh samples only.

Source files
------------

// File: rtl/neuron_mac.sv
// ============================================================================
// neuron_mac
// ----------------------------------------------------------------------------
// Multiply-accumulate core for one neuron. Each pass streams NUM_INPUTS
// signed samples. Every sample is multiplied by a weight that an external
// synchronous ROM returns one cycle after w_addr. The products are summed with
// saturation, the bias is added, and the result is presented for one cycle
// on out_valid / out_sum. Passes may run back to back and may contain gaps.
//
// Pipeline (T = cycle in which a sample is accepted):
//   stage 1 (edge ending T)   : capture sample, valid and "last index" flag
//   stage 2 (edge ending T+1) : full-precision product with the ROM weight
//   stage 3 (edge ending T+2) : saturating accumulate; on the last sample
//                               add the bias, publish out_sum, clear acc
//   out_valid is high during cycle T+3 for the final sample of a pass.
//
// Parameters
//   DATA_WIDTH       : width of samples and weights (two's complement)
//   WEIGHT_INT_WIDTH : integer bits of the weight (1 sign, int, fraction)
//   NUM_INPUTS       : samples per pass, 2..65535
//
// Ports
//   clk       : in  clock, all state on rising edge
//   rst_n     : in  asynchronous active-low reset
//   clear     : in  synchronous abort of the current pass
//   in_valid  : in  in_data valid this cycle (no backpressure)
//   in_data   : in  signed sample, DATA_WIDTH
//   w_addr    : out weight ROM address (= current input index)
//   w_data    : in  signed weight, valid one cycle after w_addr
//   bias      : in  signed bias in product format, 2*DATA_WIDTH
//   out_valid : out one-cycle pulse, out_sum valid
//   out_sum   : out signed saturated neuron sum, 2*DATA_WIDTH, held until
//               the next out_valid
// ============================================================================
module neuron_mac #(
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int NUM_INPUTS       = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic [$clog2(NUM_INPUTS)-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]           w_data,
    input  logic [2*DATA_WIDTH-1:0]         bias,
    output logic                            out_valid,
    output logic [2*DATA_WIDTH-1:0]         out_sum
);

    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int ACC_W = 2 * DATA_WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Parameter sanity checks, evaluated at elaboration only.
    if (NUM_INPUTS < 2 || NUM_INPUTS > 65535) begin : g_bad_num_inputs
        $error("neuron_mac: NUM_INPUTS must lie in 2..65535");
    end
    if (WEIGHT_INT_WIDTH < 0 || WEIGHT_INT_WIDTH > DATA_WIDTH - 1) begin : g_bad_weight_int
        $error("neuron_mac: WEIGHT_INT_WIDTH must lie in 0..DATA_WIDTH-1");
    end

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    accept;

    logic signed [DATA_WIDTH-1:0] d1;
    logic                         v1;
    logic                         last1;

    logic signed [ACC_W-1:0] prod;
    logic                    v2;
    logic                    last2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_full;
    logic signed [ACC_W-1:0] acc_step;
    logic signed [ACC_W-1:0] biased;

    // Saturating add: one guard bit detects overflow, which can only happen
    // when the guard bit and the result sign disagree.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    // A sample arriving together with clear is thrown away.
    assign accept = in_valid && !clear;

    // The ROM is addressed directly from the index, so its one-cycle read
    // latency lines the weight up with the stage-1 sample register.
    assign w_addr = idx;

    // Both operands are widened with sign extension first, so the product
    // is exact: a DATA_WIDTH x DATA_WIDTH signed product always fits ACC_W.
    assign prod_full = ACC_W'(d1) * ACC_W'($signed(w_data));
    assign acc_step  = sat_add(acc, prod);
    assign biased    = sat_add(acc_step, bias);

    // Input index: counts accepted samples and wraps at the end of a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (in_valid) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Stage 1: capture the sample and remember whether it closes the pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1    <= '0;
            v1    <= 1'b0;
            last1 <= 1'b0;
        end else begin
            d1    <= $signed(in_data);
            v1    <= accept;
            last1 <= (idx == LAST_IDX);
        end
    end

    // Stage 2: multiply by the weight that the ROM returned this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            v2    <= 1'b0;
            last2 <= 1'b0;
        end else begin
            prod  <= prod_full;
            v2    <= v1 && !clear;
            last2 <= last1;
        end
    end

    // Stage 3: accumulate. On the final product the accumulator is zeroed
    // in the same edge, so a next pass's first product one cycle later
    // starts from zero without a bubble. out_sum is only written here and
    // therefore holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (v2) begin
                if (last2) begin
                    out_sum   <= biased;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_step;
                end
            end
        end
    end

    // Pass tracking: ACCUM from the first accepted sample until the final
    // product has been accumulated with nothing else in the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (v2 && last2 && !v1 && !accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// ============================================================================
// tb_neuron_mac
// ----------------------------------------------------------------------------
// Self-checking bench for neuron_mac (DATA_WIDTH=16, NUM_INPUTS=4). A small
// weight ROM model answers w_addr with one cycle of latency. Every driven
// sample updates a reference accumulator; when a pass completes the expected
// sum and the cycle it must appear in are queued, and a negedge monitor pops
// and compares them whenever out_valid is seen.
// ============================================================================
module tb_neuron_mac;

    localparam int DW = 16;
    localparam int NI = 4;

    typedef struct {
        logic [31:0] sum;
        int          cycle;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    w_addr;
    logic [DW-1:0] w_data = '0;
    logic [31:0]   bias;
    logic          out_valid;
    logic [31:0]   out_sum;

    logic [DW-1:0] rom [0:NI-1];
    exp_t          sb [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            model_idx;
    longint        model_acc;
    logic [31:0]   hold_sum;

    always #5 clk = ~clk;

    neuron_mac #(
        .DATA_WIDTH(DW),
        .WEIGHT_INT_WIDTH(4),
        .NUM_INPUTS(NI)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_data(in_data),
        .w_addr(w_addr),
        .w_data(w_data),
        .bias(bias),
        .out_valid(out_valid),
        .out_sum(out_sum)
    );

    // Synchronous weight ROM with one cycle of read latency.
    always @(posedge clk) w_data <= rom[w_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Output monitor: each pulse must match the head of the scoreboard in
    // value and cycle; between pulses out_sum must keep the last result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_sum", out_sum, e.sum);
                    checkOutput("out_latency", cyc, e.cycle);
                    hold_sum = e.sum;
                end
            end else begin
                checkOutput("out_sum_hold", out_sum, hold_sum);
            end
        end
    end

    // Drive one cycle of input and update the reference model.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic valid);
        longint p;
        longint total;
        exp_t   e;
        @(posedge clk);
        #1;
        in_valid = valid;
        in_data  = data;
        if (valid) begin
            checkOutput("w_addr", w_addr, model_idx);
            p = longint'($signed(data)) * longint'($signed(rom[model_idx]));
            model_acc = clamp32(model_acc + p);
            if (model_idx == NI - 1) begin
                total   = clamp32(model_acc + longint'($signed(bias)));
                e.sum   = total[31:0];
                e.cycle = cyc + 3;
                sb.push_back(e);
                model_acc = 0;
                model_idx = 0;
            end else begin
                model_idx++;
            end
        end
    endtask

    task automatic runPass(input logic [DW-1:0] data, input int gap);
        for (int i = 0; i < NI; i++) begin
            applyStimulus(data, 1'b1);
            for (int g = 0; g < gap; g++) applyStimulus('0, 1'b0);
        end
    endtask

    task automatic runRandomPass(input int gap);
        for (int i = 0; i < NI; i++) begin
            applyStimulus(DW'($urandom), 1'b1);
            for (int g = 0; g < gap; g++) applyStimulus('0, 1'b0);
        end
    endtask

    // Idle until every queued result has been seen, bounded.
    task automatic drain();
        applyStimulus('0, 1'b0);
        for (int i = 0; i < 30 && sb.size() != 0; i++) applyStimulus('0, 1'b0);
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        applyStimulus('0, 1'b0);
    endtask

    task automatic setRom(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic doClear();
        @(posedge clk);
        #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        model_idx = 0;
        model_acc = 0;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("w_addr_after_clear", w_addr, 0);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_sum", out_sum, 0);
        checkOutput("reset_w_addr", w_addr, 0);
        sb.delete();
        hold_sum  = '0;
        model_idx = 0;
        model_acc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bias      = '0;
        hold_sum  = '0;
        model_idx = 0;
        model_acc = 0;
        setRom(16'h0, 16'h0, 16'h0, 16'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("init_out_valid", out_valid, 0);
        checkOutput("init_out_sum", out_sum, 0);
        checkOutput("init_w_addr", w_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] nominal pass");
        setRom(16'h0800, 16'h0800, 16'h0800, 16'h0800);
        bias = 32'h0;
        runPass(16'h0100, 0);
        drain();
        checkOutput("nominal_const", out_sum, 32'h00200000);

        $display("[TB] positive saturation");
        setRom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        runPass(16'h7FFF, 0);
        drain();
        checkOutput("pos_sat_const", out_sum, 32'h7FFFFFFF);

        $display("[TB] negative saturation with bias");
        bias = 32'h00001000;
        runPass(16'h8000, 0);
        drain();
        checkOutput("neg_sat_const", out_sum, 32'h80001000);

        $display("[TB] bias only");
        bias = 32'hFFFF0000;
        runPass(16'h0000, 0);
        drain();
        checkOutput("bias_only_const", out_sum, 32'hFFFF0000);

        $display("[TB] back-to-back passes then gapped pass");
        setRom(16'h0123, 16'hFE00, 16'h0480, 16'h7001);
        bias = 32'h00000777;
        for (int i = 0; i < 2 * NI; i++) applyStimulus(DW'($urandom), 1'b1);
        runRandomPass(2);
        drain();

        $display("[TB] abort with clear");
        setRom(16'h0400, 16'h0200, 16'hFC00, 16'h0100);
        bias = 32'h00000010;
        applyStimulus(16'h1111, 1'b1);
        applyStimulus(16'h2222, 1'b1);
        doClear();
        runPass(16'h0300, 0);
        drain();

        $display("[TB] abort with reset");
        applyStimulus(16'h5555, 1'b1);
        applyStimulus(16'h6666, 1'b1);
        applyReset();
        runPass(16'hFF00, 0);
        drain();

        $display("[TB] random passes with random gaps");
        for (int n = 0; n < 6; n++) begin
            setRom(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
            bias = $urandom;
            runRandomPass($urandom_range(0, 2));
            runRandomPass(0);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
